credit_buffer: RTL
==================

CREDIT_BUFFER -- requirements
Module: credit_buffer

Interface
REQ-001 Parameter DEPTH, default 8, is the number of beat entries stored and SHALL be >= 2; it equals the upstream creditor's MAX_IN_TRANSIT.
REQ-002 Parameter type data_t, default logic[31:0], is the per-element data type carried on ndata_i.
REQ-003 Parameter NUM_ELEMENTS, default 1, is the number of elements per beat.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in  ndata_i.s  data_t x NUM_ELEMENTS, keep NUM_ELEMENTS, last 1, valid 1, ready 1  credited beats from the upstream creditor.
REQ-007 out  ndata_i.m  same shape as in  beats to the downstream consumer.
REQ-008 credit_return  output  1  one-cycle pulse per beat that leaves via out.
REQ-009 fill_level  output  $clog2(DEPTH)+1  current number of stored beats.
REQ-010 overflow  output  1  sticky flag: a credit-protocol violation occurred.

Function
REQ-011 The block SHALL be a FIFO of DEPTH entries, each holding {data, keep, last} unmodified.
REQ-012 Push: in.valid && in.ready; pop: out.valid && out.ready.
REQ-013 in.ready SHALL equal (fill_level != DEPTH), derived from registered state only; no combinational path from out.ready.
REQ-014 out.valid SHALL equal (fill_level != 0); out.data/keep/last SHALL present the head entry.
REQ-015 Latency: a beat pushed in cycle N SHALL be visible on out no earlier than cycle N+1; there is no same-cycle bypass when empty.
REQ-016 fill_level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-017 When full, push is blocked even if a pop occurs in the same cycle.
REQ-018 Write and read pointers SHALL wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
REQ-019 credit_return SHALL be registered: high for exactly one cycle, the cycle after each pop, and low otherwise.
REQ-020 Back-to-back pops in consecutive cycles SHALL produce credit_return high in consecutive cycles, one pulse per pop.
REQ-021 Total credit_return pulses SHALL equal total pops; no pulse SHALL be dropped or merged.
REQ-022 Once in.valid is high while fill_level == DEPTH, overflow SHALL set and hold until reset; the beat is not stored and state is unaffected.
REQ-023 While out.valid is high and out.ready is low, the head beat SHALL remain stable.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear the pointers, fill_level, credit_return and overflow, independent of clk.
REQ-025 During reset, out.valid = 0, in.ready = 0 and credit_return = 0.
REQ-026 Storage contents need no reset.
REQ-027 A mid-operation reset SHALL discard stored beats without emitting credit_return pulses; the upstream creditor is reset in the same domain.
REQ-028 in.ready SHALL rise in the first cycle after rst_n deasserts.

Structure
REQ-029 No new package typedefs are required; the entry struct {data_t[NUM_ELEMENTS], keep, last} and the pointer widths are local to the module.
REQ-030 Storage SHALL be an inline register array with no sub-module.
REQ-031 The ndata_i interface definition SHALL be reused unchanged.

Verification (DEPTH=4)
REQ-032 Push 4 beats with out.ready=0 -> fill_level=4, in.ready=0, no credit_return, overflow=0.
REQ-033 From full, hold out.ready=1 for 4 cycles -> beats exit in order with last preserved; credit_return high in 4 consecutive cycles, each one cycle after its pop; fill_level returns to 0.
REQ-034 Continuous push and pop with both valid and ready at 1 for 20 beats (data 0..19) -> fill_level steady at 1, output order 0..19, pointers wrap 5 times, 20 credit_return pulses.
REQ-035 Full buffer with in.valid=1 for 1 cycle -> overflow=1, held until reset; stored contents and order unchanged.
REQ-036 Assert rst_n low with 3 beats stored, between clock edges -> out.valid=0 immediately, fill_level=0, no credit_return; the next beat after release is output first.
REQ-037 Pair with a creditor of MAX_IN_TRANSIT=4 under random out.ready -> overflow never sets, credits conserved, and the creditor's count returns to 4 when idle.

Source files
------------

// File: rtl/credit_buffer_pkg.sv
// Shared helpers for the credit buffer: pointer arithmetic for arbitrary (non power-of-two) depths.
package credit_buffer_pkg;

    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/ndata_i.sv
// Valid/ready beat channel carrying NUM_ELEMENTS elements of data_t plus per-element keep and a last flag.
interface ndata_i #(
    parameter type         data_t       = logic [31:0],
    parameter int unsigned NUM_ELEMENTS = 1
);
    data_t [NUM_ELEMENTS-1:0] data;
    logic  [NUM_ELEMENTS-1:0] keep;
    logic                     last;
    logic                     valid;
    logic                     ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/credit_buffer.sv
// Credit-return FIFO: stores up to DEPTH beats from a credited upstream and returns one credit per beat
// delivered downstream. Sized to the creditor's in-transit limit, so any push attempt while full is a protocol error.
module credit_buffer
    import credit_buffer_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter type         data_t       = logic [31:0],
    parameter int unsigned NUM_ELEMENTS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ndata_i.s                        in,
    ndata_i.m                        out,
    output logic                     credit_return,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        data_t [NUM_ELEMENTS-1:0] data;
        logic  [NUM_ELEMENTS-1:0] keep;
        logic                     last;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_fill;
    logic             r_credit;
    logic             r_overflow;
    logic             r_active;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    entry_t           w_wr_entry;
    entry_t           w_head;

    // r_active holds in.ready low during reset and releases it on the first clock afterwards.
    assign w_full     = (r_fill == CNT_W'(DEPTH));
    assign w_empty    = (r_fill == '0);
    assign in.ready   = r_active && !w_full;
    assign out.valid  = !w_empty;
    assign w_push     = in.valid && in.ready;
    assign w_pop      = out.valid && out.ready;

    assign w_wr_entry = '{data: in.data, keep: in.keep, last: in.last};
    assign w_head     = r_mem[r_rd_ptr];
    assign out.data   = w_head.data;
    assign out.keep   = w_head.keep;
    assign out.last   = w_head.last;

    assign credit_return = r_credit;
    assign fill_level    = r_fill;
    assign overflow      = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_credit <= w_pop;
            if (w_push) begin
                r_wr_ptr <= PTR_W'(wrap_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= PTR_W'(wrap_inc(32'(r_rd_ptr), DEPTH));
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_fill <= r_fill - CNT_W'(1);
            end
            if (in.valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

endmodule
